titan_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the Titan pipeline.
- Replaces the single-word fetch path between the IF stage and the instruction Wishbone port.
- Runs ahead of the pipeline by fetching sequential words into a DEPTH-entry queue. Each entry holds PC, instruction and fault tags.
- Supports redirect (branch/jump/exception) with flush of queued and in-flight words, without violating Wishbone classic cycle rules.

---
 rtl/titan_fetch_queue.sv | 213 +++++++++++++++++++++
 tb/tb_titan_fetch_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/titan_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// titan_fetch_queue - run-ahead instruction fetch queue on a Wishbone classic
// port; TITAN_FETCH_QUEUE_STATS_EN adds fetched/discarded counters.  Rev 1.0
// ----------------------------------------------------------------------------
module titan_fetch_queue #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                DEPTH      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              deq_ready_i,
  output logic              deq_valid_o,
  output logic [ADDR_W-1:0] deq_pc_o,
  output logic [31:0]       deq_inst_o,
  output logic              deq_access_fault_o,
  output logic              deq_misaligned_o,
  output logic [ADDR_W-1:0] iwbm_addr_o,
  output logic              iwbm_cyc_o,
  output logic              iwbm_stb_o,
  input  logic [31:0]       iwbm_dat_i,
  input  logic              iwbm_ack_i,
  input  logic              iwbm_err_i
`ifdef TITAN_FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]       stat_fetched_o,
  output logic [31:0]       stat_discarded_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, count;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [DEPTH-1:0]  fault_mem, mis_mem;

  logic        empty, full, in_flight, credit_ok, bus_done, deq_fire;
  logic        pc_misaligned, redirect_aligned;
  logic        enq, enq_fault, enq_mis;
  logic [31:0] enq_inst;

  assign count            = wr_ptr - rd_ptr;
  assign empty            = (wr_ptr == rd_ptr);
  assign full             = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                            (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign in_flight        = (state == S_REQ) || (state == S_DISCARD);
  assign credit_ok        = !full && ((32'(count) + 32'(in_flight)) < 32'(DEPTH));
  assign bus_done         = iwbm_cyc_o && (iwbm_ack_i || iwbm_err_i);
  assign deq_fire         = deq_valid_o && deq_ready_i;
  assign pc_misaligned    = (fetch_pc[1:0] != 2'b00);
  assign redirect_aligned = (redirect_pc_i[1:0] == 2'b00);

  assign deq_valid_o        = !empty;
  assign deq_pc_o           = pc_mem[rd_ptr[IDX_W-1:0]];
  assign deq_inst_o         = inst_mem[rd_ptr[IDX_W-1:0]];
  assign deq_access_fault_o = fault_mem[rd_ptr[IDX_W-1:0]];
  assign deq_misaligned_o   = mis_mem[rd_ptr[IDX_W-1:0]];

  // A redirect suppresses every enqueue, including a same-cycle bus response.
  always_comb begin
    enq       = 1'b0;
    enq_inst  = '0;
    enq_fault = 1'b0;
    enq_mis   = 1'b0;
    if (!redirect_i) begin
      case (state)
        S_IDLE: begin
          if (credit_ok && pc_misaligned) begin
            enq     = 1'b1;
            enq_mis = 1'b1;
          end
        end
        S_REQ: begin
          if (iwbm_ack_i) begin
            enq      = 1'b1;
            enq_inst = iwbm_dat_i;
          end else if (iwbm_err_i) begin
            enq       = 1'b1;
            enq_fault = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fault_mem <= '0;
      mis_mem   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) begin
        pc_mem[wr_ptr[IDX_W-1:0]]    <= fetch_pc;
        inst_mem[wr_ptr[IDX_W-1:0]]  <= enq_inst;
        fault_mem[wr_ptr[IDX_W-1:0]] <= enq_fault;
        mis_mem[wr_ptr[IDX_W-1:0]]   <= enq_mis;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_ADDR;
      iwbm_addr_o <= RESET_ADDR;
      iwbm_cyc_o  <= 1'b0;
      iwbm_stb_o  <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      if (in_flight) begin
        // An outstanding cycle must still complete before the bus is reused.
        if (bus_done) begin
          state      <= S_IDLE;
          iwbm_cyc_o <= 1'b0;
          iwbm_stb_o <= 1'b0;
        end else begin
          state <= S_DISCARD;
        end
      end else if (redirect_aligned) begin
        state       <= S_REQ;
        iwbm_addr_o <= redirect_pc_i;
        iwbm_cyc_o  <= 1'b1;
        iwbm_stb_o  <= 1'b1;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (credit_ok) begin
            if (pc_misaligned) begin
              state <= S_HALT;
            end else begin
              state       <= S_REQ;
              iwbm_addr_o <= fetch_pc;
              iwbm_cyc_o  <= 1'b1;
              iwbm_stb_o  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (iwbm_ack_i) begin
            state      <= S_IDLE;
            fetch_pc   <= fetch_pc + ADDR_W'(4);
            iwbm_cyc_o <= 1'b0;
            iwbm_stb_o <= 1'b0;
          end else if (iwbm_err_i) begin
            state      <= S_HALT;
            iwbm_cyc_o <= 1'b0;
            iwbm_stb_o <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (bus_done) begin
            state      <= S_IDLE;
            iwbm_cyc_o <= 1'b0;
            iwbm_stb_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TITAN_FETCH_QUEUE_STATS_EN
  logic fetched_inc, discarded_inc;

  assign fetched_inc   = !redirect_i && (state == S_REQ) && iwbm_ack_i;
  assign discarded_inc = bus_done &&
                         ((state == S_DISCARD) || ((state == S_REQ) && redirect_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_fetched_o   <= '0;
      stat_discarded_o <= '0;
    end else begin
      if (fetched_inc && (stat_fetched_o != 32'hFFFF_FFFF)) begin
        stat_fetched_o <= stat_fetched_o + 32'd1;
      end
      if (discarded_inc && (stat_discarded_o != 32'hFFFF_FFFF)) begin
        stat_discarded_o <= stat_discarded_o + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_titan_fetch_queue.sv
`default_nettype none
// tb_titan_fetch_queue - directed stimulus with a scoreboard of expected
// dequeued entries and a bus responder logging issued fetch addresses.
module tb_titan_fetch_queue;

  logic        clk;
  logic        rst_ni;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic        deq_fault;
  logic        deq_mis;
  logic [31:0] wb_addr;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat;
  logic        wb_ack;
  logic        wb_err;
`ifdef TITAN_FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_discarded;
`endif

  titan_fetch_queue #(
    .ADDR_W    (32),
    .RESET_ADDR(32'h0000_0100),
    .DEPTH     (4)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .redirect_i        (redirect),
    .redirect_pc_i     (redirect_pc),
    .deq_ready_i       (deq_ready),
    .deq_valid_o       (deq_valid),
    .deq_pc_o          (deq_pc),
    .deq_inst_o        (deq_inst),
    .deq_access_fault_o(deq_fault),
    .deq_misaligned_o  (deq_mis),
    .iwbm_addr_o       (wb_addr),
    .iwbm_cyc_o        (wb_cyc),
    .iwbm_stb_o        (wb_stb),
    .iwbm_dat_i        (wb_dat),
    .iwbm_ack_i        (wb_ack),
    .iwbm_err_i        (wb_err)
`ifdef TITAN_FETCH_QUEUE_STATS_EN
    ,
    .stat_fetched_o    (stat_fetched),
    .stat_discarded_o  (stat_discarded)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic        mis;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] bus_log[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          deq_budget = 0;
  int          ack_delay  = 0;
  int          resp_wcnt  = 0;
  logic        err_en     = 1'b0;
  logic [31:0] err_addr   = 32'h0;
  int          base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < bus_log.size()) return bus_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic entry_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic fault, input logic mis);
    entry_t e;
    e.pc = pc; e.inst = inst; e.fault = fault; e.mis = mis;
    return e;
  endfunction

  // Bus slave: responds after ack_delay wait cycles; data = addr ^ CAFE_0000.
  initial begin
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_dat = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (wb_cyc && wb_stb) begin
        if (resp_wcnt >= ack_delay) begin
          if (err_en && (wb_addr == err_addr)) begin
            wb_err = 1'b1;
          end else begin
            wb_ack = 1'b1;
            wb_dat = wb_addr ^ 32'hCAFE_0000;
          end
          bus_log.push_back(wb_addr);
          resp_wcnt = 0;
        end else begin
          resp_wcnt++;
        end
      end else begin
        resp_wcnt = 0;
      end
    end
  end

  // Consumer: one dequeue per unit of budget.
  initial begin
    deq_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      deq_ready = (deq_budget > 0);
    end
  end

  // Monitor: every accepted head entry is checked against the scoreboard.
  always @(negedge clk) begin : monitor
    entry_t e;
    if (rst_ni && deq_valid && deq_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_deq: got pc %h, expected no entry", deq_pc);
      end else begin
        e = exp_q.pop_front();
        check("deq_pc", deq_pc, e.pc);
        if (!e.fault) check("deq_inst", deq_inst, e.inst);
        check("deq_access_fault", 32'(deq_fault), 32'(e.fault));
        check("deq_misaligned", 32'(deq_mis), 32'(e.mis));
      end
      if (deq_budget > 0) deq_budget--;
    end
  end

  task automatic apply_reset(input bit do_check);
    rst_ni      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq_budget  = 0;
    err_en      = 1'b0;
    exp_q.delete();
    bus_log.delete();
    repeat (3) @(posedge clk);
    #2;
    if (do_check) begin
      check("rst_deq_valid", 32'(deq_valid), 32'h0);
      check("rst_deq_pc", deq_pc, 32'h0);
      check("rst_deq_inst", deq_inst, 32'h0);
      check("rst_flags", {30'h0, deq_fault, deq_mis}, 32'h0);
      check("rst_cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
      check("rst_addr", wb_addr, 32'h0000_0100);
    end
    rst_ni = 1'b1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk);
    #2;
    redirect = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr, input int limit);
    bit found = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(posedge clk);
      #2;
      if (wb_cyc && wb_stb && (wb_addr == addr)) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'h1);
  endtask

  task automatic wait_drained(input string name, input int limit);
    for (int n = 0; n < limit && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #2;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Streaming from RESET_ADDR with zero-wait acks.
    ack_delay = 0;
    apply_reset(1'b1);
    exp_q.push_back(mk(32'h0000_0100, 32'hCAFE_0100, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0000_0104, 32'hCAFE_0104, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0000_0108, 32'hCAFE_0108, 1'b0, 1'b0));
    deq_budget = 3;
    wait_drained("stream_drain", 50);
    check("stream_addr0", log_at(0), 32'h0000_0100);
    check("stream_addr1", log_at(1), 32'h0000_0104);
    check("stream_addr2", log_at(2), 32'h0000_0108);

    // Credit limit: four fetches with no consumer, then one per dequeue.
    apply_reset(1'b0);
    repeat (30) @(posedge clk);
    #2;
    check("credit_fetches", bus_log.size(), 4);
    check("credit_cyc_low", 32'(wb_cyc), 32'h0);
    exp_q.push_back(mk(32'h0000_0100, 32'hCAFE_0100, 1'b0, 1'b0));
    deq_budget = 1;
    wait_drained("credit_drain", 20);
    repeat (10) @(posedge clk);
    #2;
    check("credit_refill_count", bus_log.size(), 5);
    check("credit_refill_addr", log_at(4), 32'h0000_0110);
    check("credit_cyc_low2", 32'(wb_cyc), 32'h0);

    // Redirect during a slow cycle: cycle completes, response dropped.
    ack_delay = 3;
    apply_reset(1'b0);
    wait_req("discard_wait_10c", 32'h0000_010C, 60);
    do_redirect(32'h0000_2000);
    check("discard_cyc_held", {30'h0, wb_cyc, wb_stb}, 32'h3);
    check("discard_addr_held", wb_addr, 32'h0000_010C);
    exp_q.push_back(mk(32'h0000_2000, 32'hCAFE_2000, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0000_2004, 32'hCAFE_2004, 1'b0, 1'b0));
    deq_budget = 2;
    wait_drained("discard_drain", 80);
    check("discard_old_addr", log_at(3), 32'h0000_010C);
    check("discard_new_addr", log_at(4), 32'h0000_2000);
`ifdef TITAN_FETCH_QUEUE_STATS_EN
    check("stat_discarded", stat_discarded, 32'h1);
`endif

    // Redirect coincident with an ack.
    ack_delay = 0;
    apply_reset(1'b0);
    wait_req("coinc_wait_104", 32'h0000_0104, 20);
    do_redirect(32'h0000_3000);
    check("coinc_cyc_drop", 32'(wb_cyc), 32'h0);
    exp_q.push_back(mk(32'h0000_3000, 32'hCAFE_3000, 1'b0, 1'b0));
    deq_budget = 1;
    wait_drained("coinc_drain", 30);
    check("coinc_ack_addr", log_at(1), 32'h0000_0104);
    check("coinc_next_addr", log_at(2), 32'h0000_3000);

    // Bus error halts fetching until a redirect.
    apply_reset(1'b0);
    repeat (15) @(posedge clk);
    #2;
    base     = bus_log.size();
    err_en   = 1'b1;
    err_addr = 32'h0000_0040;
    do_redirect(32'h0000_0040);
    exp_q.push_back(mk(32'h0000_0040, 32'h0, 1'b1, 1'b0));
    deq_budget = 1;
    wait_drained("err_drain", 30);
    repeat (10) @(posedge clk);
    #2;
    check("err_addr", log_at(base), 32'h0000_0040);
    check("err_halt_count", bus_log.size(), base + 1);
    check("err_halt_cyc", 32'(wb_cyc), 32'h0);
    err_en = 1'b0;
    do_redirect(32'h0000_0080);
    exp_q.push_back(mk(32'h0000_0080, 32'hCAFE_0080, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0000_0084, 32'hCAFE_0084, 1'b0, 1'b0));
    deq_budget = 2;
    wait_drained("err_resume_drain", 40);
    check("err_resume_addr", log_at(base + 1), 32'h0000_0080);

    // Misaligned redirect: no bus access, one flagged entry, then halt.
    repeat (15) @(posedge clk);
    #2;
    base = bus_log.size();
    do_redirect(32'h0000_0202);
    exp_q.push_back(mk(32'h0000_0202, 32'h0, 1'b0, 1'b1));
    deq_budget = 1;
    wait_drained("mis_drain", 20);
    repeat (10) @(posedge clk);
    #2;
    check("mis_no_bus", bus_log.size(), base);
    check("mis_cyc_low", 32'(wb_cyc), 32'h0);
    check("mis_queue_empty", 32'(deq_valid), 32'h0);

    // Reset asserted mid-cycle.
    ack_delay = 5;
    apply_reset(1'b0);
    wait_req("midrst_wait", 32'h0000_0100, 20);
    rst_ni = 1'b0;
    #1;
    check("midrst_cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    check("midrst_addr", wb_addr, 32'h0000_0100);
    ack_delay = 0;
    bus_log.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_ni = 1'b1;
    exp_q.push_back(mk(32'h0000_0100, 32'hCAFE_0100, 1'b0, 1'b0));
    deq_budget = 1;
    wait_drained("midrst_drain", 30);
    check("midrst_restart_addr", log_at(0), 32'h0000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
